// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// clocks-per-bit derivation used by both the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_t;

   localparam int   DATA_BITS  = 8;
   localparam logic STOP_LEVEL = 1'b1;

   function automatic int baud_div(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the rx pin plus the per-sample bit value.
// With UART_RX_MAJORITY_EN the bit value is a 2-of-3 vote over the last three rx_s taps.
module uart_rx_sync
   import uart_pkg::*;
(
   input  logic clk50m,
   input  logic reset,
   input  logic rx,
   output logic rx_s,
   output logic rx_bit
);

   logic [1:0] sync_q;

   always_ff @(posedge clk50m) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], rx};
      end
   end

   assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
   // hist_q[0] is rx_s one clock ago, hist_q[1] two clocks ago
   logic [1:0] hist_q;

   always_ff @(posedge clk50m) begin
      if (reset) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= {hist_q[0], rx_s};
      end
   end

   assign rx_bit = maj3(hist_q[1], hist_q[0], rx_s);
`else
   assign rx_bit = rx_s;
`endif

endmodule

// File: rtl/uart_rx_byte.sv
// UART 8N1 receiver with mid-bit sampling and a valid/ready holding register.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (adds one clock of latency).
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       clk50m,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
   localparam int CW       = $clog2(BAUD_DIV);
   localparam int IW       = $clog2(DATA_BITS);

`ifdef UART_RX_MAJORITY_EN
   localparam int LAG = 1;
`else
   localparam int LAG = 0;
`endif

   // Majority mode decides one clock after the start-bit centre; every later
   // sample point inherits that shift through the counter restart.
   localparam logic [CW-1:0] START_PT = CW'(BAUD_DIV / 2 - 1 + LAG);
   localparam logic [CW-1:0] BIT_PT   = CW'(BAUD_DIV - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   logic rx_s;
   logic rx_bit;

   uart_rx_sync u_sync (
      .clk50m (clk50m),
      .reset  (reset),
      .rx     (rx),
      .rx_s   (rx_s),
      .rx_bit (rx_bit)
   );

   rx_state_t            state_q;
   logic [CW-1:0]        cnt_q;
   logic [IW-1:0]        bit_idx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 done_q;
   logic                 frame_err_q;
   logic                 busy_q;

   always_ff @(posedge clk50m) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         frame_err_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_q <= START;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            START: begin
               if (cnt_q == START_PT) begin
                  cnt_q <= '0;
                  if (!rx_bit) begin
                     state_q   <= DATA;
                     bit_idx_q <= '0;
                  end else begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == BIT_PT) begin
                  cnt_q   <= '0;
                  shift_q <= {rx_bit, shift_q[DATA_BITS-1:1]};
                  if (bit_idx_q == LAST_BIT) begin
                     state_q <= STOP;
                  end else begin
                     bit_idx_q <= bit_idx_q + 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (cnt_q == BIT_PT) begin
                  cnt_q <= '0;
                  if (rx_bit == STOP_LEVEL) begin
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= WAIT_HIGH;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            WAIT_HIGH: begin
               // A held-low (break) line must not look like a new start bit
               if (rx_s) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   logic [7:0] data_q, data_d;
   logic       valid_q, valid_d;
   logic       overrun_q, overrun_d;

   // A completed byte may replace the held one only if the held one leaves this cycle
   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (valid_q && rx_ready) begin
         valid_d = 1'b0;
      end
      if (done_q) begin
         if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk50m) begin
      if (reset) begin
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign rx_data   = data_q;
   assign rx_valid  = valid_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at BAUD_DIV = 10: fixed vectors, corner sequences
// and random frames scored against a waveform-sampling model of an 8N1 receiver.
`timescale 1ns/1ps
module tb_uart_rx_byte;

   localparam int CLK_FREQ  = 50000000;
   localparam int BAUD_RATE = 5000000;
   localparam int D         = CLK_FREQ / BAUD_RATE;
   localparam int FRAME     = 10 * D;
`ifdef UART_RX_MAJORITY_EN
   localparam bit MAJ = 1'b1;
`else
   localparam bit MAJ = 1'b0;
`endif
   localparam int LAT = 2 + 1 + D / 2 + 9 * D + 1 + (MAJ ? 1 : 0);

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   always #5 clk = ~clk;

   uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
      .clk50m    (clk),
      .reset     (reset),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fe_cnt = 0, ov_cnt = 0, valid_cycles = 0, rise_cyc = -1;
   logic prev_valid = 1'b0;
   logic [7:0] got_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   // Observe 1 ns before each rising edge: inputs are settled and a handshake
   // seen here is the one the next edge performs.
   always @(negedge clk) begin
      #4;
      if (rx_valid && !prev_valid) rise_cyc = cyc;
      prev_valid = rx_valid;
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end else begin
         $display("ok   %s: %0h", name, got);
      end
   endtask

   // Per-clock line levels of one frame, played by the driver and decoded by the model
   logic wave [FRAME];

   task automatic build(input logic [7:0] d, input logic stop_ok, input bit spike);
      for (int k = 0; k < 10; k++) begin
         logic lvl;
         lvl = (k == 0) ? 1'b0 : (k == 9) ? stop_ok : d[k-1];
         for (int j = 0; j < D; j++)
            wave[k*D+j] = (spike && k >= 1 && k <= 8 && j == D / 2) ? ~lvl : lvl;
      end
   endtask

   task automatic play_n(input int n);
      for (int i = 0; i < n; i++) begin
         rx = wave[i];
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Reference receiver: read each bit at its centre clock (2-of-3 around it when voting)
   function automatic logic sample_at(input int i);
      if (MAJ)
         return (wave[i-1] & wave[i]) | (wave[i-1] & wave[i+1]) | (wave[i] & wave[i+1]);
      return wave[i];
   endfunction

   function automatic logic [8:0] model_frame();
      logic [7:0] b;
      for (int k = 1; k <= 8; k++) b[k-1] = sample_at(k * D + D / 2);
      return {sample_at(9 * D + D / 2), b};
   endfunction

   typedef struct {
      logic [7:0] data;
      logic       stop_ok;
      logic       exp_del;
      logic [7:0] exp_data;
      logic       exp_fe;
   } vec_t;

   vec_t vecs [6];
   int   fe0, ov0, vc0, n0, fall_cyc, cnt_a;
   logic [7:0] exp_q [$];
   logic [8:0] mr;

   initial begin
      vecs[0] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
      vecs[1] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
      vecs[2] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0};
      vecs[3] = '{8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[4] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0};
      vecs[5] = '{8'hC7, 1'b0, 1'b0, 8'h00, 1'b1};

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_rx_data", 32'(rx_data), 32'h00);
      check("reset_rx_valid", 32'(rx_valid), 32'h0);
      check("reset_frame_err", 32'(frame_err), 32'h0);
      check("reset_overrun", 32'(overrun), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      reset = 1'b0;
      idle(5);

      // Single frame, consumer always ready: latency and one-cycle valid
      rx_ready = 1'b1;
      fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cycles; n0 = got_q.size(); rise_cyc = -1;
      build(8'hA5, 1'b1, 1'b0);
      fall_cyc = cyc;
      play_n(FRAME);
      idle(5);
      check("t1_latency", 32'(rise_cyc - fall_cyc), 32'(LAT));
      check("t1_count", 32'(got_q.size() - n0), 32'd1);
      if (got_q.size() > n0) check("t1_data", 32'(got_q[n0]), 32'hA5);
      check("t1_valid_cycles", 32'(valid_cycles - vc0), 32'd1);
      check("t1_no_fe", 32'(fe_cnt - fe0), 32'd0);
      check("t1_no_ov", 32'(ov_cnt - ov0), 32'd0);

      // Back-to-back frames with consumer stalled: overrun keeps the first byte
      rx_ready = 1'b0;
      fe0 = fe_cnt; ov0 = ov_cnt; n0 = got_q.size();
      build(8'h3C, 1'b1, 1'b0);
      play_n(FRAME);
      check("t2_first_held", 32'(rx_data), 32'h3C);
      build(8'hC3, 1'b1, 1'b0);
      play_n(FRAME);
      idle(5);
      check("t2_valid_held", 32'(rx_valid), 32'h1);
      check("t2_data_held", 32'(rx_data), 32'h3C);
      check("t2_overrun", 32'(ov_cnt - ov0), 32'd1);
      rx_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("t2_valid_cleared", 32'(rx_valid), 32'h0);
      check("t2_accepted", 32'(got_q.size() - n0), 32'd1);
      if (got_q.size() > n0) check("t2_accepted_data", 32'(got_q[n0]), 32'h3C);
      check("t2_no_fe", 32'(fe_cnt - fe0), 32'd0);

      // Framing error followed by a break of 30 bit times
      fe0 = fe_cnt; vc0 = valid_cycles;
      build(8'h55, 1'b0, 1'b0);
      play_n(FRAME);
      cnt_a = 0;
      for (int i = 0; i < 30 * D; i++) begin
         rx = 1'b0;
         if (!busy) cnt_a++;
         @(negedge clk);
      end
      check("t3_busy_during_break", 32'(cnt_a), 32'd0);
      check("t3_frame_err_once", 32'(fe_cnt - fe0), 32'd1);
      idle(3 * D);
      check("t3_busy_after_release", 32'(busy), 32'h0);
      check("t3_no_valid", 32'(valid_cycles - vc0), 32'd0);
      check("t3_no_extra_fe", 32'(fe_cnt - fe0), 32'd1);

      // Three-clock low glitch on an idle line
      fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cycles;
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      cnt_a = 0;
      for (int i = 0; i < 3 * D; i++) begin
         if (busy) cnt_a++;
         @(negedge clk);
      end
      check("t4_start_seen", 32'(cnt_a > 0), 32'h1);
      check("t4_busy_idle", 32'(busy), 32'h0);
      check("t4_no_valid", 32'(valid_cycles - vc0), 32'd0);
      check("t4_no_fe", 32'(fe_cnt - fe0), 32'd0);
      check("t4_no_ov", 32'(ov_cnt - ov0), 32'd0);

      // Reset mid-frame drops both the held byte and the partial one
      rx_ready = 1'b0;
      build(8'h99, 1'b1, 1'b0);
      play_n(FRAME);
      idle(3);
      check("t5_held_before_reset", 32'(rx_valid), 32'h1);
      build(8'hFF, 1'b1, 1'b0);
      play_n(5 * D);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_rx_data", 32'(rx_data), 32'h00);
      check("t5_rx_valid", 32'(rx_valid), 32'h0);
      check("t5_busy", 32'(busy), 32'h0);
      check("t5_frame_err", 32'(frame_err), 32'h0);
      check("t5_overrun", 32'(overrun), 32'h0);
      idle(2 * D);
      rx_ready = 1'b1;
      n0 = got_q.size();
      build(8'h12, 1'b1, 1'b0);
      play_n(FRAME);
      idle(5);
      check("t5_after_count", 32'(got_q.size() - n0), 32'd1);
      if (got_q.size() > n0) check("t5_after_data", 32'(got_q[n0]), 32'h12);

      // Spike at every data-bit centre
      n0 = got_q.size();
      build(8'h81, 1'b1, 1'b1);
      mr = model_frame();
      play_n(FRAME);
      idle(5);
      check("t6_count", 32'(got_q.size() - n0), 32'd1);
      if (got_q.size() > n0) begin
         check("t6_vs_model", 32'(got_q[n0]), 32'(mr[7:0]));
         check("t6_vs_const", 32'(got_q[n0]), MAJ ? 32'h81 : 32'h7E);
      end

      // Table-driven vectors
      for (int v = 0; v < 6; v++) begin
         fe0 = fe_cnt; n0 = got_q.size();
         build(vecs[v].data, vecs[v].stop_ok, 1'b0);
         play_n(FRAME);
         idle(3 * D);
         check($sformatf("vec%0d_count", v), 32'(got_q.size() - n0), 32'(vecs[v].exp_del));
         if (vecs[v].exp_del && got_q.size() > n0)
            check($sformatf("vec%0d_data", v), 32'(got_q[n0]), 32'(vecs[v].exp_data));
         check($sformatf("vec%0d_fe", v), 32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
      end

      // Random frames against the model
      fe0 = fe_cnt; ov0 = ov_cnt; n0 = got_q.size(); cnt_a = 0;
      for (int r = 0; r < 12; r++) begin
         logic [7:0] d;
         logic       ok;
         d  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 3) != 0);
         build(d, ok, 1'b0);
         mr = model_frame();
         if (mr[8]) exp_q.push_back(mr[7:0]);
         else cnt_a++;
         play_n(FRAME);
         idle(ok ? $urandom_range(0, 20) : $urandom_range(3, 20));
      end
      idle(3 * D);
      check("rand_count", 32'(got_q.size() - n0), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && n0 + i < got_q.size(); i++)
         check($sformatf("rand_byte%0d", i), 32'(got_q[n0+i]), 32'(exp_q[i]));
      check("rand_fe", 32'(fe_cnt - fe0), 32'(cnt_a));
      check("rand_no_ov", 32'(ov_cnt - ov0), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
